// File: rtl/rot_cmd_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : rot_cmd_feeder
//  Description : Command FIFO plus beat sequencer that feeds a barrel rotator,
//                either a single rotation or a full 0..2**M-1 sweep per command.
//                The sweep mode is compiled in only when ROT_CMD_SWEEP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module rot_cmd_feeder #(
    parameter int N     = 8,
    parameter int M     = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    input  logic [M-1:0]               in_shift,
    input  logic                       in_sweep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               input_bits,
    output logic [M-1:0]               shift_pattern,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SWEEP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    bits_q;
    logic [M-1:0]    shift_q;
    logic            last_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [N-1:0]    mem_data  [DEPTH];
    logic [M-1:0]    mem_shift [DEPTH];

    logic            push;
    logic            pop;
    logic            xfer;
    logic            final_xfer;
    logic            head_sweep;
    logic [M-1:0]    shift_inc;

    // in_ready depends only on registered occupancy: a pop never bypasses a full FIFO
    assign in_ready   = (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign out_valid  = (state_q != IDLE);
    assign xfer       = out_valid && out_ready;
    assign final_xfer = xfer && last_q;
    assign pop        = ((state_q == IDLE) || final_xfer) && (count_q != '0);
    assign count_d    = count_q + CW'(push) - CW'(pop);
    assign shift_inc  = shift_q + M'(1);

    assign input_bits    = bits_q;
    assign shift_pattern = shift_q;
    assign out_last      = last_q;
    assign fifo_count    = count_q;

`ifdef ROT_CMD_SWEEP_EN
    logic            mem_sweep [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_sweep[wr_ptr_q] <= in_sweep;
        end
    end

    assign head_sweep = mem_sweep[rd_ptr_q];
`else
    logic            unused_sweep;

    assign unused_sweep = in_sweep;
    assign head_sweep   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q]  <= in_data;
            mem_shift[wr_ptr_q] <= in_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Loading on the final-beat edge keeps consecutive commands bubble-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bits_q  <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
        end else if (pop) begin
            bits_q <= mem_data[rd_ptr_q];
            if (head_sweep) begin
                state_q <= SWEEP;
                shift_q <= '0;
                last_q  <= 1'b0;
            end else begin
                state_q <= SINGLE;
                shift_q <= mem_shift[rd_ptr_q];
                last_q  <= 1'b1;
            end
        end else if (final_xfer) begin
            state_q <= IDLE;
            bits_q  <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
`ifdef ROT_CMD_SWEEP_EN
        end else if (xfer && (state_q == SWEEP)) begin
            shift_q <= shift_inc;
            last_q  <= (shift_inc == '1);
`endif
        end
    end

`ifndef ROT_CMD_SWEEP_EN
    logic [M-1:0] unused_inc;
    assign unused_inc = shift_inc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rot_cmd_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rot_cmd_feeder
//  Description : Directed self-checking bench for rot_cmd_feeder (both builds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rot_cmd_feeder;

    localparam int N     = 8;
    localparam int M     = 3;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [N-1:0]  in_data   = '0;
    logic [M-1:0]  in_shift  = '0;
    logic          in_sweep  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  input_bits;
    logic [M-1:0]  shift_pattern;
    logic          out_last;
    logic [2:0]    fifo_count;

    int n_vec = 0;
    int n_err = 0;

    rot_cmd_feeder #(.N(N), .M(M), .DEPTH(DEPTH)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_shift      (in_shift),
        .in_sweep      (in_sweep),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .input_bits    (input_bits),
        .shift_pattern (shift_pattern),
        .out_last      (out_last),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] d, input logic [M-1:0] s, input logic sw);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_sweep = sw;
    endtask

    task automatic expect_beat(input string tag, input logic [N-1:0] d, input logic [M-1:0] s,
                               input logic l);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".bits"},  32'(input_bits), 32'(d));
        check_eq({tag, ".shift"}, 32'(shift_pattern), 32'(s));
        check_eq({tag, ".last"},  32'(out_last), 32'(l));
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".bits"},  32'(input_bits), 32'd0);
        check_eq({tag, ".shift"}, 32'(shift_pattern), 32'd0);
        check_eq({tag, ".last"},  32'(out_last), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $finish;
    end

    initial begin
        logic [3:0] pat;
        logic [M-1:0] exp_s;
        logic done;
        int cyc;

        // Reset state
        #2;
        expect_idle("rst");
        check_eq("rst.ready", 32'(in_ready), 32'd1);
        check_eq("rst.count", 32'(fifo_count), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Single command: one-cycle load latency, one beat, back to idle
        out_ready = 1'b1;
        drive(8'hB4, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        check_eq("single.count", 32'(fifo_count), 32'd1);
        check_eq("single.lat", 32'(out_valid), 32'd0);
        tick();
        expect_beat("single", 8'hB4, 3'd3, 1'b1);
        check_eq("single.count0", 32'(fifo_count), 32'd0);
        tick();
        expect_idle("single.end");

`ifdef ROT_CMD_SWEEP_EN
        // Sweep: eight consecutive beats 0..7
        drive(8'h81, 3'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        for (int b = 0; b < 8; b++) begin
            expect_beat($sformatf("sweep%0d", b), 8'h81, M'(b), (b == 7));
            tick();
        end
        expect_idle("sweep.end");
`else
        // Sweep flag ignored: single beat
        drive(8'h0F, 3'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        expect_beat("nosweep", 8'h0F, 3'd2, 1'b1);
        tick();
        expect_idle("nosweep.end");
`endif

        // Backpressure: output stage occupied, then five pushes fill the FIFO
        out_ready = 1'b0;
        drive(8'h20, 3'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(8'h20 + 8'(i), M'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        check_eq("full.count", 32'(fifo_count), 32'd4);
        check_eq("full.ready", 32'(in_ready), 32'd0);
        expect_beat("full.hold", 8'h20, 3'd0, 1'b1);
        out_ready = 1'b1;
        check_eq("full.nobypass", 32'(in_ready), 32'd0);
        for (int j = 0; j < 5; j++) begin
            expect_beat($sformatf("drain%0d", j), 8'h20 + 8'(j), M'(j), 1'b1);
            check_eq($sformatf("drain%0d.count", j), 32'(fifo_count), 32'(4 - j));
            tick();
        end
        expect_idle("drain.end");
        check_eq("drain.count", 32'(fifo_count), 32'd0);

`ifdef ROT_CMD_SWEEP_EN
        // Stall stability during a sweep with ready pattern 1,0,0,1
        drive(8'h5A, 3'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        pat   = 4'b1001;
        exp_s = '0;
        done  = 1'b0;
        cyc   = 0;
        while (!done && cyc < 24) begin
            out_ready = pat[cyc % 4];
            expect_beat($sformatf("stall%0d", cyc), 8'h5A, exp_s, (exp_s == 3'd7));
            tick();
            if (out_ready) begin
                if (exp_s == 3'd7) done = 1'b1;
                else exp_s = exp_s + 3'd1;
            end
            cyc++;
        end
        check_eq("stall.done", 32'(done), 32'd1);
        expect_idle("stall.end");

        // Reset at beat 3 of a sweep with two commands queued
        out_ready = 1'b1;
        drive(8'hC3, 3'd0, 1'b1);
        tick();
        drive(8'h11, 3'd1, 1'b0);
        tick();
        drive(8'h22, 3'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        expect_beat("midsweep", 8'hC3, 3'd3, 1'b0);
        check_eq("midsweep.count", 32'(fifo_count), 32'd2);
`else
        // Stall stability for a single beat
        out_ready = 1'b0;
        drive(8'h5A, 3'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        expect_beat("stall0", 8'h5A, 3'd6, 1'b1);
        tick();
        expect_beat("stall1", 8'h5A, 3'd6, 1'b1);
        out_ready = 1'b1;
        tick();
        expect_idle("stall.end");

        // Reset with one beat held and two commands queued
        out_ready = 1'b0;
        drive(8'hC3, 3'd0, 1'b1);
        tick();
        drive(8'h11, 3'd1, 1'b0);
        tick();
        drive(8'h22, 3'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        expect_beat("held", 8'hC3, 3'd0, 1'b1);
        check_eq("held.count", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
`endif
        #1 rst_n = 1'b0;
        drive(8'h3C, 3'd5, 1'b0);
        #1;
        expect_idle("arst");
        check_eq("arst.count", 32'(fifo_count), 32'd0);
        check_eq("arst.ready", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("post.count", 32'(fifo_count), 32'd1);
        check_eq("post.valid", 32'(out_valid), 32'd0);
        tick();
        expect_beat("post", 8'h3C, 3'd5, 1'b1);
        tick();
        expect_idle("post.end");
        check_eq("post.count0", 32'(fifo_count), 32'd0);
        tick();
        check_eq("post.stale", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
